alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter alu_width, default 8, data-path width in bits; SHALL support any value 4..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  operation enable.
REQ-005 a  input  alu_width  first operand (data being operated on).
REQ-006 b  input  alu_width  second operand, or shift/rotate amount, or bit index.
REQ-007 opcode  input  alu_op  operation select (enum from shared package).
REQ-008 out  output  alu_width  combinational result.
REQ-009 status_flag  output  8  registered flag register, Z80 layout: [7]S [6]Z [5]0 [4]H [3]0 [2]P/V [1]N [0]C.

Function
REQ-010 out SHALL be purely combinational from enable, a, b, opcode; zero cycles of latency.
REQ-011 enable=0 SHALL force out=0 and hold status_flag unchanged.
REQ-012 ADD: out = a+b mod 2^w; C = carry out; H = carry from bit 3; P/V = signed overflow; N=0.
REQ-013 SUB: out = a-b mod 2^w; C = borrow; H = borrow from bit 4; P/V = signed overflow; N=1.
REQ-014 INC: out = a+1; DEC: out = a-1; H, P/V, N as ADD/SUB respectively; C held.
REQ-015 AND/OR/XOR: bitwise; C=0, N=0, P/V = even parity of out; H=1 for AND, else 0.
REQ-016 SLL and SLA: out = a << b; b >= w gives 0.
REQ-017 SRL: out = a >> b, zero fill; b >= w gives 0.
REQ-018 SRA: arithmetic right shift, sign fill; b >= w gives all ones if a[msb]=1, else 0.
REQ-019 ROL/ROR: rotate by (b mod w); b=0 or multiple of w returns a.
REQ-020 Shifts/rotates: C = last bit shifted/rotated out (0 when effective amount is 0, or when b > w for shifts); H=0, N=0, P/V = even parity of out.
REQ-021 SET: out = a with bit (b mod w) forced to 1; RESET: same bit forced to 0; flags held.
REQ-022 TEST: out = a; Z = inverse of bit (b mod w) of a; H=1, N=0; other flags held.
REQ-023 For all flag-updating ops except TEST: S = out[w-1], Z = (out==0); bits 5 and 3 always 0.
REQ-024 status_flag SHALL load on the rising clk edge when enable=1, from the current combinational result; visible one cycle after the operation.
REQ-025 Undefined opcode encodings SHALL give out=0 and hold flags.

Reset
REQ-026 reset=1 on a rising edge SHALL clear status_flag to 8'h00; reset has priority over enable.
REQ-027 out is not reset (combinational); reset mid-operation only affects the flag register.

Structure
REQ-028 Shared package SHALL hold typedef enum alu_op (4-bit): ADD, SUB, AND, OR, XOR, SLL, SRL, SLA, SRA, ROL, ROR, INC, DEC, SET, RESET, TEST, encoded 0..15 in that order, plus flag bit-position constants.
REQ-029 One sub-module natural: alu_shifter (shift/rotate datapath with carry-out); remainder inline.

Verification
REQ-030 Arithmetic: w=8, ADD 7+7 -> out 14; SUB 7-7 -> out 0, next cycle Z=1, N=1, C=0; ADD 0xFF+1 -> 0, C=1, Z=1, H=1.
REQ-031 Logic: AND 0x0D,7 -> 5; OR 0xCB,0x2B -> 0xEB; XOR 0xFF,0x8A -> 0x75; XOR 7,7 -> 0, Z=1, P/V=1.
REQ-032 Shifts: SLL 0x07,3 -> 0x38; SLL 0x0F,6 -> 0xC0; SLL 0x0F,9 -> 0; SRL 0xCA,3 -> 0x19; SRL 0xCA,8 -> 0; SRA 0xCA,3 -> 0xF9; SRA 0x4A,3 -> 0x09; SRA 0xCA,8 -> 0xFF; SRA 0x4A,8 -> 0.
REQ-033 Rotates: ROL 0xCA,3 -> 0x56; ROL 0x80,10 -> 0x02; ROR 0xCA,3 -> 0x59; ROR 0x80,10 -> 0x20.
REQ-034 Parity: SLL 0x02,0 -> out 2, P/V=0, C=0; SLL 0x03,0 -> out 3, P/V=1.
REQ-035 Control: enable=0 -> out 0, flags unchanged; reset asserted with enable=1 -> flags 0x00 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: operation encoding and flag-register bit positions.
// Imported by alu, alu_shifter and the bench.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SLA   = 4'd7,
    OP_SRA   = 4'd8,
    OP_ROL   = 4'd9,
    OP_ROR   = 4'd10,
    OP_INC   = 4'd11,
    OP_DEC   = 4'd12,
    OP_SET   = 4'd13,
    OP_RESET = 4'd14,
    OP_TEST  = 4'd15
  } alu_op;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_H  = 4;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

endpackage

// File: rtl/alu_shifter.sv
// Shift/rotate datapath with carry-out (last bit shifted or rotated out).
// Ports: a data, b amount, opcode select; res result, carry bit out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int alu_width = 8
) (
  input  logic [alu_width-1:0] a,
  input  logic [alu_width-1:0] b,
  input  alu_op                opcode,
  output logic [alu_width-1:0] res,
  output logic                 carry
);

  localparam int unsigned W = alu_width;
  localparam logic [alu_width-1:0] WV = W[alu_width-1:0];

  logic [alu_width:0]   sll;
  logic [alu_width:0]   srl;
  logic [alu_width:0]   sra;
  logic [alu_width-1:0] rot;
  logic [alu_width-1:0] rol;
  logic [alu_width-1:0] ror;

  always_comb begin
    // Extra guard bit catches the last bit shifted out (0 for b=0).
    sll = {1'b0, a} << b;
    srl = {a, 1'b0} >> b;
    sra = $signed({a, 1'b0}) >>> b;
    rot = b % WV;
    // A shift by WV (rot=0) yields 0, so rot=0 returns a.
    rol = (a << rot) | (a >> (WV - rot));
    ror = (a >> rot) | (a << (WV - rot));
    res   = '0;
    carry = 1'b0;
    case (opcode)
      OP_SLL, OP_SLA: begin
        if (b <= WV) {carry, res} = sll;
      end
      OP_SRL: begin
        if (b <= WV) {res, carry} = srl;
      end
      OP_SRA: begin
        if (b <= WV) {res, carry} = sra;
        else         res = {alu_width{a[alu_width-1]}};
      end
      OP_ROL: begin
        res   = rol;
        carry = (rot != '0) && rol[0];
      end
      OP_ROR: begin
        res   = ror;
        carry = (rot != '0) && ror[alu_width-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Combinational ALU with a registered Z80-style flag byte.
// Ports: clk, reset (sync high), enable, a, b, opcode; out, status_flag.
module alu
  import alu_pkg::*;
#(
  parameter int alu_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [alu_width-1:0] a,
  input  logic [alu_width-1:0] b,
  input  alu_op                opcode,
  output logic [alu_width-1:0] out,
  output logic [7:0]           status_flag
);

  localparam int M = alu_width - 1;
  localparam int unsigned W = alu_width;
  localparam logic [alu_width-1:0] WV = W[alu_width-1:0];
  localparam logic [alu_width-1:0] ONE =
    {{(alu_width-1){1'b0}}, 1'b1};

  logic [7:0]           status_flag_q;
  logic [7:0]           status_flag_d;
  logic [alu_width-1:0] sh_res;
  logic                 sh_c;
  logic [alu_width-1:0] addend;
  logic [alu_width:0]   x;
  logic [alu_width:0]   y;
  logic [alu_width:0]   sum;
  logic [alu_width:0]   diff;
  logic [alu_width-1:0] idx;
  logic [alu_width-1:0] mask;
  logic [alu_width-1:0] res;
  logic [7:0]           f;
  logic                 hc_add;
  logic                 hc_sub;
  logic                 ov_add;
  logic                 ov_sub;
  logic                 upd_sz;

  alu_shifter #(
    .alu_width(alu_width)
  ) u_shifter (
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .res    (sh_res),
    .carry  (sh_c)
  );

  always_comb begin
    addend = (opcode == OP_INC || opcode == OP_DEC) ? ONE : b;
    x      = {1'b0, a};
    y      = {1'b0, addend};
    sum    = x + y;
    diff   = x - y;
    // Carry/borrow into bit 4 recovered from operand and result bits.
    hc_add = x[4] ^ y[4] ^ sum[4];
    hc_sub = x[4] ^ y[4] ^ diff[4];
    ov_add = (a[M] == addend[M]) && (sum[M] != a[M]);
    ov_sub = (a[M] != addend[M]) && (diff[M] != a[M]);
    idx    = b % WV;
    mask   = ONE << idx;
    res    = '0;
    f      = status_flag_q;
    upd_sz = 1'b0;
    case (opcode)
      OP_ADD, OP_INC: begin
        res       = sum[M:0];
        f[FLAG_H] = hc_add;
        f[FLAG_PV] = ov_add;
        f[FLAG_N] = 1'b0;
        if (opcode == OP_ADD) f[FLAG_C] = sum[alu_width];
        upd_sz    = 1'b1;
      end
      OP_SUB, OP_DEC: begin
        res       = diff[M:0];
        f[FLAG_H] = hc_sub;
        f[FLAG_PV] = ov_sub;
        f[FLAG_N] = 1'b1;
        if (opcode == OP_SUB) f[FLAG_C] = diff[alu_width];
        upd_sz    = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR: begin
        if (opcode == OP_AND)     res = a & b;
        else if (opcode == OP_OR) res = a | b;
        else                      res = a ^ b;
        f[FLAG_H]  = (opcode == OP_AND);
        f[FLAG_PV] = ~^res;
        f[FLAG_N]  = 1'b0;
        f[FLAG_C]  = 1'b0;
        upd_sz     = 1'b1;
      end
      OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_ROL, OP_ROR: begin
        res        = sh_res;
        f[FLAG_H]  = 1'b0;
        f[FLAG_PV] = ~^res;
        f[FLAG_N]  = 1'b0;
        f[FLAG_C]  = sh_c;
        upd_sz     = 1'b1;
      end
      OP_SET:   res = a | mask;
      OP_RESET: res = a & ~mask;
      OP_TEST: begin
        res       = a;
        f[FLAG_Z] = ~|(a & mask);
        f[FLAG_H] = 1'b1;
        f[FLAG_N] = 1'b0;
      end
      default: res = '0;
    endcase
    if (upd_sz) begin
      f[FLAG_S] = res[M];
      f[FLAG_Z] = ~|res;
    end
    f[5] = 1'b0;
    f[3] = 1'b0;
    out           = enable ? res : '0;
    status_flag_d = enable ? f : status_flag_q;
  end

  always_ff @(posedge clk) begin
    if (reset) status_flag_q <= 8'h00;
    else       status_flag_q <= status_flag_d;
  end

  assign status_flag = status_flag_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu (w=8): directed vectors push expectations,
// a monitor pops and checks out plus the flag byte after each edge.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    string      nm;
    logic [7:0] eo;
    logic [7:0] ef;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  alu_op      opcode = OP_ADD;
  logic [7:0] out;
  logic [7:0] status_flag;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu #(.alu_width(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .a           (a),
    .b           (b),
    .opcode      (opcode),
    .out         (out),
    .status_flag (status_flag)
  );

  always #5 clk = ~clk;

  task automatic drv(input logic r, input logic en,
                     input alu_op op, input logic [7:0] va,
                     input logic [7:0] vb, input logic [7:0] eo,
                     input logic [7:0] ef, input string nm);
    exp_t e;
    @(negedge clk);
    reset  = r;
    enable = en;
    opcode = op;
    a      = va;
    b      = vb;
    e.nm = nm;
    e.eo = eo;
    e.ef = ef;
    sb.push_back(e);
  endtask

  // Inputs change on negedge, so #1 after posedge out still reflects
  // the vector and status_flag holds its flags.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (out !== e.eo) begin
          n_bad++;
          $display("FAIL %s out: got %h want %h", e.nm, out, e.eo);
        end
        n_cmp++;
        if (status_flag !== e.ef) begin
          n_bad++;
          $display("FAIL %s flags: got %h want %h",
                   e.nm, status_flag, e.ef);
        end
      end
    end
  end

  initial begin
    drv(1, 1, OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, "rst_add");
    drv(0, 1, OP_ADD, 8'h07, 8'h07, 8'h0E, 8'h00, "add_7_7");
    drv(0, 1, OP_SUB, 8'h07, 8'h07, 8'h00, 8'h42, "sub_7_7");
    drv(0, 1, OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h51, "add_ff_1");
    drv(0, 1, OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h94, "add_ovf");
    drv(0, 1, OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h16, "sub_ovf");
    drv(0, 1, OP_SUB, 8'h00, 8'h01, 8'hFF, 8'h93, "sub_brw");
    drv(0, 1, OP_INC, 8'hFF, 8'h55, 8'h00, 8'h51, "inc_ff");
    drv(0, 1, OP_AND, 8'h0D, 8'h07, 8'h05, 8'h14, "and");
    drv(0, 1, OP_DEC, 8'h00, 8'h55, 8'hFF, 8'h92, "dec_0");
    drv(0, 1, OP_OR,  8'hCB, 8'h2B, 8'hEB, 8'h84, "or");
    drv(0, 1, OP_XOR, 8'hFF, 8'h8A, 8'h75, 8'h00, "xor");
    drv(0, 1, OP_XOR, 8'h07, 8'h07, 8'h00, 8'h44, "xor_z");
    drv(0, 1, OP_SLL, 8'h07, 8'd3,  8'h38, 8'h00, "sll_3");
    drv(0, 1, OP_SLL, 8'h0F, 8'd6,  8'hC0, 8'h85, "sll_6");
    drv(0, 1, OP_SLL, 8'h0F, 8'd9,  8'h00, 8'h44, "sll_9");
    drv(0, 1, OP_SLL, 8'h81, 8'd8,  8'h00, 8'h45, "sll_8");
    drv(0, 1, OP_SRL, 8'hCA, 8'd3,  8'h19, 8'h00, "srl_3");
    drv(0, 1, OP_SRL, 8'hCA, 8'd8,  8'h00, 8'h45, "srl_8");
    drv(0, 1, OP_SRA, 8'hCA, 8'd3,  8'hF9, 8'h84, "sra_n3");
    drv(0, 1, OP_SRA, 8'h4A, 8'd3,  8'h09, 8'h04, "sra_p3");
    drv(0, 1, OP_SRA, 8'hCA, 8'd8,  8'hFF, 8'h85, "sra_n8");
    drv(0, 1, OP_SRA, 8'h4A, 8'd8,  8'h00, 8'h44, "sra_p8");
    drv(0, 1, OP_SRA, 8'hCA, 8'd9,  8'hFF, 8'h84, "sra_n9");
    drv(0, 1, OP_ROL, 8'hCA, 8'd3,  8'h56, 8'h04, "rol_3");
    drv(0, 1, OP_ROL, 8'h80, 8'd10, 8'h02, 8'h00, "rol_10");
    drv(0, 1, OP_ROR, 8'hCA, 8'd3,  8'h59, 8'h04, "ror_3");
    drv(0, 1, OP_ROR, 8'h80, 8'd10, 8'h20, 8'h00, "ror_10");
    drv(0, 1, OP_ROR, 8'h01, 8'd1,  8'h80, 8'h81, "ror_c");
    drv(0, 1, OP_ROL, 8'hCA, 8'd8,  8'hCA, 8'h84, "rol_8");
    drv(0, 1, OP_SLL, 8'h02, 8'd0,  8'h02, 8'h00, "par_odd");
    drv(0, 1, OP_SLL, 8'h03, 8'd0,  8'h03, 8'h04, "par_even");
    drv(0, 1, OP_SLA, 8'h81, 8'd1,  8'h02, 8'h01, "sla_1");
    drv(0, 1, OP_SET, 8'h00, 8'd10, 8'h04, 8'h01, "set");
    drv(0, 1, OP_RESET, 8'hFF, 8'd7, 8'h7F, 8'h01, "reset_bit");
    drv(0, 1, OP_TEST, 8'h10, 8'd4, 8'h10, 8'h11, "test_1");
    drv(0, 1, OP_TEST, 8'h10, 8'd3, 8'h10, 8'h51, "test_0");
    drv(0, 0, OP_ADD, 8'h7F, 8'h01, 8'h00, 8'h51, "disabled");
    drv(1, 1, OP_SUB, 8'h00, 8'h01, 8'hFF, 8'h00, "rst_pri");
    drv(0, 1, OP_XOR, 8'h0F, 8'hF0, 8'hFF, 8'h84, "post_rst");
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
